// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction stream encoder.
// Format codes, FSM states, NOP word and common opcodes.
package instr_enc_pkg;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_S = 2'b10;
  localparam logic [1:0] FMT_B = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } enc_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_S    = 7'h23;
  localparam logic [6:0] OP_B    = 7'h63;

endpackage

// File: rtl/instr_stream_encoder_fifo.sv
// enc_fifo: synchronous FIFO with registered storage and full/empty flags.
// Ports: clk, rst_n, i_push/i_wdata, i_pop/o_rdata, o_full, o_empty.
module enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit separates full from empty when indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Packs decoded RV32I fields into words and streams them to instr memory.
// Ports: start, in_* bundle (valid/ready), mem_* write port, busy/done/err.
// Optional INSTR_ENC_IMM_CHECK_EN: out-of-range immediates become NOP + err.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              w_accept;
  logic              w_write;
  logic [31:0]       w_packed;
  logic [31:0]       w_word;
  logic [31:0]       w_head;
  logic              w_full;
  logic              w_empty;

  function automatic logic [31:0] pack(
    input logic [1:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic        f75,
    input logic [12:0] imm
  );
    logic [31:0] w;
    w = '0;
    unique case (fmt)
      FMT_R: w = {1'b0, f75, 5'b0, rs2, rs1, f3, rd, op};
      FMT_I: w = {imm[11:0], rs1, f3, rd, op};
      FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B: w = {imm[12], imm[10:5], rs2, rs1, f3,
                  imm[4:1], imm[11], op};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign w_packed = pack(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                         in_funct3, in_funct7_5, in_imm);

  // in_ready looks only at registered state and FIFO flags.
  assign in_ready = (r_state == STREAM) && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_write  = mem_we && mem_ready;

`ifdef INSTR_ENC_IMM_CHECK_EN
  logic w_bad;
  logic r_err;

  always_comb begin
    w_bad = 1'b0;
    unique case (1'b1)
      (in_fmt == FMT_I): w_bad = in_imm[12] ^ in_imm[11];
      (in_fmt == FMT_S): w_bad = in_imm[12] ^ in_imm[11];
      (in_fmt == FMT_B): w_bad = in_imm[0];
      default:           w_bad = 1'b0;
    endcase
  end

  assign w_word = w_bad ? NOP : w_packed;

  // Sticky; only a fresh load from DONE (or reset) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == DONE && start) begin
      r_err <= 1'b0;
    end else if (w_accept && w_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_word = w_packed;
  assign err    = 1'b0;
`endif

  enc_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_wdata (w_word),
    .i_pop   (w_write),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign mem_we    = !w_empty;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_empty ? 32'h0 : w_head;
  assign busy      = (r_state == STREAM) || (r_state == DRAIN);
  assign done      = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= BASE;
    end else begin
      if (w_write) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= STREAM;
            r_addr  <= BASE;
          end
        end
        STREAM: begin
          if (w_accept && in_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_empty) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            r_state <= STREAM;
            r_addr  <= BASE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
